// File: rtl/gpio_pkg.sv
// Constants and bus request type shared by the GPIO-side wishbone slaves.
package gpio_pkg;

    localparam logic [1:0] GPD_STATE = 2'd0;
    localparam logic [1:0] GPD_DIV   = 2'd1;
    localparam logic [1:0] GPD_PEND  = 2'd2;
    localparam logic [1:0] GPD_MASK  = 2'd3;

    typedef struct packed {
        logic        stb;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } gpd_req_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchroniser and a tick-driven consecutive-sample debouncer.
module debounce_bit #(
    parameter int   THRESH = 4,
    parameter logic RST_ST = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_pin,
    output logic o_st,
    output logic o_chg
);

    localparam int CW = 4;

    logic          s1_q, s2_q, st_q;
    logic [CW-1:0] cnt_q;
    logic          differ, at_thr;

    assign differ = (s2_q != st_q);
    assign at_thr = (cnt_q == CW'(THRESH - 1));
    // Combinational so the pending flag sets on the same edge the level flips.
    assign o_chg  = i_tick && differ && at_thr;
    assign o_st   = st_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            st_q  <= RST_ST;
            cnt_q <= '0;
        end else begin
            s1_q <= i_pin;
            s2_q <= s1_q;
            if (i_tick) begin
                if (!differ) begin
                    cnt_q <= '0;
                end else if (at_thr) begin
                    st_q  <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_debounce.sv
// Debounced pin input block: sample-tick prescaler, per-pin cells and a
// four-register wishbone slave with latched change flags and interrupt mask.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int              NIN         = 16,
    parameter int              DIVW        = 24,
    parameter logic [DIVW-1:0] DEFAULT_DIV = 24'd99_999,
    parameter int              THRESH      = 4,
    parameter logic [15:0]     DEFAULT     = 16'h0000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [1:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_ack,
    output logic            o_wb_stall,
    output logic [31:0]     o_wb_data,
    input  logic [NIN-1:0]  i_pin,
    output logic [NIN-1:0]  o_gpio,
    output logic            o_int
);

    gpd_req_t        req;
    logic [NIN-1:0]  st, chg;
    logic [DIVW-1:0] pre_q, pre_d, div_q;
    logic [NIN-1:0]  pend_q, pend_d, mask_q;
    logic            int_q, ack_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            wr, div_wr, tick;
    logic            unused_ok;

    assign req       = '{stb: i_wb_stb, we: i_wb_we, addr: i_wb_addr, data: i_wb_data};
    assign unused_ok = ^{i_wb_cyc, i_wb_data};

    assign wr     = req.stb && req.we;
    assign div_wr = wr && (req.addr == GPD_DIV);
    // A divider write restarts the count, so it swallows any tick due this cycle.
    assign tick   = (pre_q == '0) && !div_wr;

    always_comb begin
        pre_d = pre_q - 1'b1;
        if (div_wr)
            pre_d = req.data[DIVW-1:0];
        else if (pre_q == '0)
            pre_d = div_q;
    end

    always_comb begin
        pend_d = pend_q;
        if (wr && (req.addr == GPD_PEND))
            pend_d = pend_q & ~req.data[NIN-1:0];
        pend_d = pend_d | chg;
    end

    always_comb begin
        rdata_d = '0;
        case (req.addr)
            GPD_STATE: rdata_d = 32'(st);
            GPD_DIV:   rdata_d = 32'(div_q);
            GPD_PEND:  rdata_d = 32'(pend_q);
            default:   rdata_d = 32'(mask_q);
        endcase
    end

    for (genvar i = 0; i < NIN; i++) begin : g_pin
        debounce_bit #(
            .THRESH (THRESH),
            .RST_ST (DEFAULT[i])
        ) u_bit (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_tick  (tick),
            .i_pin   (i_pin[i]),
            .o_st    (st[i]),
            .o_chg   (chg[i])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q   <= DEFAULT_DIV;
            div_q   <= DEFAULT_DIV;
            pend_q  <= '0;
            mask_q  <= '0;
            int_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pre_q  <= pre_d;
            pend_q <= pend_d;
            int_q  <= |(pend_q & mask_q);
            ack_q  <= req.stb;
            if (div_wr)
                div_q <= req.data[DIVW-1:0];
            if (wr && (req.addr == GPD_MASK))
                mask_q <= req.data[NIN-1:0];
            if (req.stb)
                rdata_q <= rdata_d;
        end
    end

    assign o_gpio     = st;
    assign o_int      = int_q;
    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Randomised and directed bench for gpio_debounce: a window-based reference
// model pushes expected read data, a negedge monitor compares outputs.
module tb_gpio_debounce;
    import gpio_pkg::*;

    localparam int THRESH = 4;
    localparam logic [23:0] DEF_DIV = 24'd99_999;
    localparam logic [15:0] DEF_ST  = 16'h00A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdat = '0;
    logic [15:0] pin = '0;
    logic        ack, stall, irq;
    logic [31:0] rdat;
    logic [15:0] gpio;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [15:0] m_st, m_pend, m_mask, m_d0, m_d1;
    logic [23:0] m_div;
    logic        m_int, m_ack;
    int          m_j;
    logic [15:0] win[$];
    logic [31:0] exp_q[$];

    gpio_debounce #(
        .NIN(16), .DIVW(24), .DEFAULT_DIV(DEF_DIV), .THRESH(THRESH), .DEFAULT(DEF_ST)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
        .i_pin(pin), .o_gpio(gpio), .o_int(irq)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pin's level is accepted once the last THRESH tick samples of the
    // synchronised pin all disagree with the currently held level.
    initial forever begin
        logic [15:0] s2v, chg;
        logic        tk, allf, ni, w;
        logic [31:0] e;
        int          dv;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = DEF_ST; m_pend = '0; m_mask = '0; m_d0 = '0; m_d1 = '0;
            m_div = DEF_DIV; m_int = 1'b0; m_ack = 1'b0; m_j = 0;
            win.delete(); exp_q.delete();
        end else begin
            s2v = m_d1;
            dv  = int'(m_div);
            tk  = ((m_j % (dv + 1)) == dv);
            w   = stb && we;
            case (addr)
                GPD_STATE: e = {16'h0, m_st};
                GPD_DIV:   e = {8'h0, m_div};
                GPD_PEND:  e = {16'h0, m_pend};
                default:   e = {16'h0, m_mask};
            endcase
            if (stb) exp_q.push_back(e);
            if (w && addr == GPD_DIV) tk = 1'b0;
            chg = '0;
            if (tk) begin
                win.push_back(s2v);
                if (win.size() > THRESH) void'(win.pop_front());
                if (win.size() == THRESH)
                    for (int i = 0; i < 16; i++) begin
                        allf = 1'b1;
                        for (int k = 0; k < THRESH; k++)
                            if (win[k][i] == m_st[i]) allf = 1'b0;
                        chg[i] = allf;
                    end
            end
            ni = |(m_pend & m_mask);
            if (w && addr == GPD_PEND) m_pend = m_pend & ~wdat[15:0];
            m_pend = m_pend | chg;
            m_st   = m_st ^ chg;
            if (w && addr == GPD_MASK) m_mask = wdat[15:0];
            if (w && addr == GPD_DIV) begin
                m_div = wdat[23:0];
                m_j   = 0;
            end else begin
                m_j++;
            end
            m_int = ni;
            m_ack = stb;
            m_d1  = m_d0;
            m_d0  = pin;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("gpio", 32'(gpio), 32'(m_st));
            chk("int", 32'(irq), 32'(m_int));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("stall", 32'(stall), 32'd0);
            if (ack) begin
                if (exp_q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
                else chk("rdata", rdat, exp_q.pop_front());
            end
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; addr = a; wdat = d;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // disturb every piece of state, then reset in the middle of a cycle
        bus(1'b1, GPD_DIV, 32'd0);
        repeat (12) @(negedge clk);
        bus(1'b1, GPD_MASK, 32'hFFFF);
        repeat (3) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = GPD_MASK; wdat = 32'hFFFF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_gpio", 32'(gpio), 32'h00A5);
        chk("rst_int", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, GPD_DIV, 32'd0);

        // settle with a tick every clock
        bus(1'b1, GPD_DIV, 32'd0);
        repeat (10) @(negedge clk);
        bus(1'b1, GPD_PEND, 32'hFFFF);

        // clean edge on pin 3: rises after edge k+5
        @(negedge clk);
        pin[3] = 1'b1;
        repeat (5) @(negedge clk);
        chk("edge_before", 32'(gpio[3]), 32'd0);
        @(negedge clk);
        chk("edge_after", 32'(gpio[3]), 32'd1);
        bus(1'b0, GPD_PEND, 32'd0);

        // glitch of 3 clocks rejected, 6 clocks accepted
        @(negedge clk);
        pin[0] = 1'b1;
        repeat (3) @(negedge clk);
        pin[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_reject", 32'(gpio[0]), 32'd0);
        bus(1'b0, GPD_PEND, 32'd0);
        pin[0] = 1'b1;
        repeat (6) @(negedge clk);
        pin[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("glitch_accept", 32'(gpio[0]), 32'd1);
        repeat (8) @(negedge clk);
        bus(1'b1, GPD_PEND, 32'hFFFF);

        // interrupt path
        bus(1'b1, GPD_MASK, 32'h0008);
        pin[3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("int_set", 32'(irq), 32'd1);
        bus(1'b1, GPD_PEND, 32'h0008);
        repeat (2) @(negedge clk);
        chk("int_clr", 32'(irq), 32'd0);

        // set beats clear on pin 5
        bus(1'b1, GPD_MASK, 32'h0020);
        @(negedge clk);
        pin[5] = 1'b1;
        repeat (5) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = GPD_PEND; wdat = 32'h0020;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        chk("set_wins_int", 32'(irq), 32'd1);
        bus(1'b0, GPD_PEND, 32'd0);

        // divider = 9: pin change to output about 2 + 4*10 clocks
        bus(1'b1, GPD_DIV, 32'd9);
        pin[3] = 1'b1;
        n = 0;
        while (gpio[3] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("div_latency_ok", 32'((n >= 32) && (n <= 52)), 32'd1);
        bus(1'b0, GPD_DIV, 32'd0);

        // randomised traffic, back-to-back strobes allowed
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 15) == 0) pin[i] = ~pin[i];
            stb  = ($urandom_range(0, 2) == 0);
            cyc  = stb;
            we   = 1'($urandom_range(0, 1));
            addr = 2'($urandom_range(0, 3));
            wdat = $urandom;
            if (we && addr == GPD_DIV) wdat = 32'($urandom_range(0, 3));
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
